// File: rtl/rv_alu_pkg.sv
// Shared ALU op codes, RV32I opcodes and skid-buffer states
// for the rv_alu_ctrl decode slice.
package rv_alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_ONE   = 2'b01,
    SB_FULL  = 2'b10
  } sb_state_e;

endpackage

// File: rtl/rv_skid_buf.sv
// Two-entry skid buffer with registered in_ready; head entry
// drives the output, tail absorbs the one-cycle ready lag.
module rv_skid_buf
  import rv_alu_pkg::*;
#(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  sb_state_e  r_state;
  sb_state_e  w_state_nxt;
  logic       r_in_ready;
  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic       w_acc;
  logic       w_hs;
  logic       w_ld_head;
  logic       w_ld_tail;
  logic       w_pop_tail;

  assign w_acc     = in_valid & r_in_ready;
  assign out_valid = (r_state != SB_EMPTY);
  assign w_hs      = out_valid & out_ready;
  assign in_ready  = r_in_ready;
  assign out_data  = r_head;

  always_comb begin
    w_state_nxt = r_state;
    w_ld_head   = 1'b0;
    w_ld_tail   = 1'b0;
    w_pop_tail  = 1'b0;
    unique case (r_state)
      SB_EMPTY: begin
        if (w_acc) begin
          w_state_nxt = SB_ONE;
          w_ld_head   = 1'b1;
        end
      end
      SB_ONE: begin
        if (w_acc && w_hs) begin
          w_ld_head = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = SB_FULL;
          w_ld_tail   = 1'b1;
        end else if (w_hs) begin
          w_state_nxt = SB_EMPTY;
        end
      end
      SB_FULL: begin
        if (w_hs) begin
          w_state_nxt = SB_ONE;
          w_pop_tail  = 1'b1;
        end
      end
      default: w_state_nxt = SB_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= SB_EMPTY;
      r_in_ready <= 1'b1;
      r_head     <= RST_VAL;
      r_tail     <= RST_VAL;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != SB_FULL);
      if (w_ld_head) begin
        r_head <= in_data;
      end else if (w_pop_tail) begin
        r_head <= r_tail;
      end
      if (w_ld_tail) begin
        r_tail <= in_data;
      end
    end
  end

endmodule

// File: rtl/rv_alu_ctrl.sv
// RV32I ALU-control decode feeding a two-entry skid buffer.
// Define RV_ALU_CTRL_ILLEGAL_EN to carry the illegal flag.
module rv_alu_ctrl
  import rv_alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    in_opcode,
  input  logic [2:0]    in_funct3,
  input  logic          in_funct7b5,
  input  logic [DW-1:0] in_rs1,
  input  logic [DW-1:0] in_rs2,
  input  logic [DW-1:0] in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_in1,
  output logic [DW-1:0] out_in2,
  output logic [3:0]    out_alu_op,
  output logic          out_illegal
);

  alu_op_e       w_op;
  logic          w_sel_imm;
  logic          w_illegal;
  logic [DW-1:0] w_in1;
  logic [DW-1:0] w_in2;

  always_comb begin
    w_op      = ALU_ADD;
    w_sel_imm = 1'b0;
    w_illegal = 1'b0;
    unique case (1'b1)
      (in_opcode == OPC_OP): begin
        unique case ({in_funct7b5, in_funct3})
          4'b0000: w_op = ALU_ADD;
          4'b1000: w_op = ALU_SUB;
          4'b0111: w_op = ALU_AND;
          4'b0110: w_op = ALU_OR;
          4'b0011: w_op = ALU_SLT;
          default: w_illegal = 1'b1;
        endcase
      end
      (in_opcode == OPC_OPIMM): begin
        w_sel_imm = 1'b1;
        unique case (in_funct3)
          3'b000:  w_op = ALU_ADD;
          3'b111:  w_op = ALU_AND;
          3'b110:  w_op = ALU_OR;
          3'b011:  w_op = ALU_SLT;
          default: w_illegal = 1'b1;
        endcase
      end
      (in_opcode == OPC_LOAD),
      (in_opcode == OPC_STORE): begin
        w_sel_imm = 1'b1;
        w_op      = ALU_ADD;
      end
      (in_opcode == OPC_BRANCH): begin
        unique case (in_funct3)
          3'b000, 3'b001: w_op = ALU_SUB;
          3'b110, 3'b111: w_op = ALU_SLT;
          default:        w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Illegal encodings leave w_op at ADD; zero the operands too.
  assign w_in1 = w_illegal ? '0 : in_rs1;
  assign w_in2 = w_illegal ? '0 :
                 (w_sel_imm ? in_imm : in_rs2);

`ifdef RV_ALU_CTRL_ILLEGAL_EN
  localparam int PW = 2*DW + 5;
  localparam logic [PW-1:0] RST_VAL =
    {1'b0, ALU_ADD, {(2*DW){1'b0}}};
  logic [PW-1:0] w_d;
  logic [PW-1:0] w_q;
  assign w_d         = {w_illegal, w_op, w_in1, w_in2};
  assign out_illegal = w_q[PW-1];
`else
  localparam int PW = 2*DW + 4;
  localparam logic [PW-1:0] RST_VAL =
    {ALU_ADD, {(2*DW){1'b0}}};
  logic [PW-1:0] w_d;
  logic [PW-1:0] w_q;
  assign w_d         = {w_op, w_in1, w_in2};
  assign out_illegal = 1'b0;
`endif

  assign out_alu_op = w_q[2*DW +: 4];
  assign out_in1    = w_q[DW +: DW];
  assign out_in2    = w_q[0 +: DW];

  rv_skid_buf #(
    .W       (PW),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_q)
  );

endmodule

// File: doc/rv_alu_ctrl.md
RV_ALU_CTRL -- requirements
Module: rv_alu_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, operand datapath width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  decode request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port in_opcode  input  7  RV32I opcode field.
REQ-007 SHALL have port in_funct3  input  3  funct3 field.
REQ-008 SHALL have port in_funct7b5  input  1  instruction bit 30.
REQ-009 SHALL have ports in_rs1, in_rs2, in_imm  input  DW each  register operands and sign-extended immediate.
REQ-010 SHALL have port out_valid  output  1  ALU request valid.
REQ-011 SHALL have port out_ready  input  1  downstream ALU stage accepts the request.
REQ-012 SHALL have ports out_in1, out_in2  output  DW each  ALU operands.
REQ-013 SHALL have port out_alu_op  output  4  ALU operation code.
REQ-014 SHALL have port out_illegal  output  1  request carries an unsupported encoding.

Function
REQ-015 Opcode 0110011 SHALL decode: funct3 000 + bit30=0 -> ADD 0010; + bit30=1 -> SUB 0110; 111 -> AND 0000; 110 -> OR 0001; 011 -> SLT 0111; operands rs1/rs2.
REQ-016 Opcode 0010011 SHALL decode funct3 000/111/110/011 to ADD/AND/OR/SLT with operands rs1/imm.
REQ-017 Opcodes 0000011 and 0100011 SHALL decode to ADD with operands rs1/imm.
REQ-018 Opcode 1100011 SHALL decode funct3 000/001 -> SUB and 110/111 -> SLT, operands rs1/rs2.
REQ-019 Every other opcode/funct3/bit30 combination SHALL be illegal; the illegal decode is ADD with both operands zero.
REQ-020 Code 1100 (NOR) SHALL never be emitted.
REQ-021 Latency SHALL be exactly one cycle from in_valid&in_ready to out_valid with an empty buffer.
REQ-022 Buffering SHALL be a two-entry skid buffer with states EMPTY, ONE and FULL.
REQ-023 EMPTY SHALL go to ONE on accept.
REQ-024 ONE SHALL stay ONE on accept with output handshake, go to FULL on accept without it, and go to EMPTY on output handshake without accept.
REQ-025 FULL SHALL go to ONE on output handshake.
REQ-026 in_ready SHALL be a registered signal, deasserted only in FULL.
REQ-027 Requests SHALL be emitted in acceptance order, with no loss or duplication.
REQ-028 out_* payload SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Sustained in_valid=1 and out_ready=1 SHALL give one request per cycle.
REQ-030 in_valid while in_ready=0 SHALL be ignored.

Reset
REQ-031 On rst=1 the block SHALL enter EMPTY, with out_valid=0, in_ready=1, out_alu_op=0010, out_in1/out_in2=0 and out_illegal=0.
REQ-032 Reset mid-operation SHALL discard all buffered requests.

Configuration
REQ-033 With RV_ALU_CTRL_ILLEGAL_EN defined, out_illegal SHALL travel with each request and equal 1 for REQ-019 encodings.
REQ-034 Without RV_ALU_CTRL_ILLEGAL_EN, out_illegal SHALL be tied 0, while decode still follows REQ-019.

Structure
REQ-035 A shared package rv_alu_pkg SHALL hold an enum of the six ALU op codes and localparams for opcodes 0110011, 0010011, 0000011, 0100011 and 1100011.
REQ-036 Decode SHALL be combinational inside rv_alu_ctrl.
REQ-037 The skid buffer SHALL be the sub-module rv_skid_buf, parameterised by payload width.

Verification
REQ-038 After reset: out_valid=0, in_ready=1, out_alu_op=0010.
REQ-039 One request, opcode 0110011, funct3 000, bit30=1, rs1=10, rs2=3, out_ready=1 -> next cycle out_valid=1, op 0110, in1=10, in2=3.
REQ-040 Opcode 0010011, funct3 011, rs1=5, imm=7 -> op 0111, in2=7. Opcode 1100011, funct3 100 -> op 0010, operands 0, out_illegal=1 with macro, 0 without.
REQ-041 Three back-to-back requests with out_ready=0 -> after second accept in_ready=0 and the third is held off. Raising out_ready -> all three emerge in order, payload stable while stalled.
REQ-042 Streaming 100 requests with out_ready=1 -> 100 outputs in 101 cycles. Random out_ready -> in-order, lossless scoreboard match.
REQ-043 rst=1 in FULL -> next cycle EMPTY, out_valid=0, no stale request emitted afterward.
